alu_cmd_issuer: RTL

//   Initiator side of the ALU command interface. Accepts register-based instructions
//   (op, rd, rs1, rs2) and reads operands from a local register file. Issues one request
//   at a time to the ALU over a valid/ready handshake, waits for the response, writes the

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_regfile.sv | 41 ++++
 rtl/alu_cmd_issuer.sv | 135 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU interface types: opcodes, flags, issuer FSM states and the request payload.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_SLL  = 3'd5,
    OP_SRL  = 3'd6,
    OP_PASS = 3'd7
  } opcode_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic overflow;
    logic negative;
  } flags_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } issuer_state_e;

  localparam int ALU_W = 32;

  typedef struct packed {
    opcode_e          op;
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
  } alu_req_t;

  // Only arithmetic ops produce meaningful carry/overflow; logic ops leave them alone.
  function automatic logic updates_carry(opcode_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic updates_overflow(opcode_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// NUM_REGS x WIDTH register file: three combinational read ports, load and writeback write ports.
module alu_regfile #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 8,
  localparam int REG_AW  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rs1_addr,
  output logic [WIDTH-1:0]  rs1_data,
  input  logic [REG_AW-1:0] rs2_addr,
  output logic [WIDTH-1:0]  rs2_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [WIDTH-1:0]  dbg_data,
  input  logic              ld_en,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [WIDTH-1:0]  ld_data,
  input  logic              wb_en,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [WIDTH-1:0]  wb_data
);

  logic [WIDTH-1:0] regs [NUM_REGS];

  assign rs1_data = regs[rs1_addr];
  assign rs2_data = regs[rs2_addr];
  assign dbg_data = regs[dbg_addr];

  // NOTE: this array is reset because software relies on every register reading zero after
  // reset; that rules out block RAM, which is acceptable at this depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (ld_en) regs[ld_addr] <= ld_data;
      // Writeback is scheduled last so it overrides a same-address load.
      if (wb_en) regs[wb_addr] <= wb_data;
    end
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// ALU command initiator: reads operands, issues one request at a time, writes back result and flags.
// Define ALU_ISSUER_PERF_EN to add the perf_instr_cnt / perf_stall_cnt counters.
import alu_pkg::*;

module alu_cmd_issuer #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 8,
  localparam int REG_AW  = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [REG_AW-1:0] instr_rd,
  input  logic [REG_AW-1:0] instr_rs1,
  input  logic [REG_AW-1:0] instr_rs2,
  input  logic              ld_en,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [WIDTH-1:0]  ld_data,
  output logic              alu_req_valid,
  input  logic              alu_req_ready,
  output logic [2:0]        alu_op,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  input  logic              alu_rsp_valid,
  input  logic [WIDTH-1:0]  alu_rsp_result,
  input  logic [3:0]        alu_rsp_flags,
  output logic [3:0]        flags_q,
  output logic              busy,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [WIDTH-1:0]  dbg_data
`ifdef ALU_ISSUER_PERF_EN
  ,
  output logic [31:0]       perf_instr_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  issuer_state_e     state, state_nxt;
  opcode_e           op_q;
  logic [REG_AW-1:0] rd_q;
  logic [WIDTH-1:0]  a_q, b_q;
  flags_t            flags_r;
  flags_t            rsp_flags;
  logic [WIDTH-1:0]  rs1_data, rs2_data;
  logic              accept, wb_en;

  assign accept    = (state == IDLE) && instr_valid;
  assign wb_en     = (state == WAIT) && alu_rsp_valid;
  assign rsp_flags = flags_t'(alu_rsp_flags);

  alu_regfile #(.WIDTH(WIDTH), .NUM_REGS(NUM_REGS)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (instr_rs1),
    .rs1_data (rs1_data),
    .rs2_addr (instr_rs2),
    .rs2_data (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .ld_en    (ld_en),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .wb_en    (wb_en),
    .wb_addr  (rd_q),
    .wb_data  (alu_rsp_result)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: default assignment first, so no path through the case leaves state_nxt unassigned
  // (which would infer a latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (instr_valid)   state_nxt = ISSUE;
      ISSUE:   if (alu_req_ready) state_nxt = WAIT;
      WAIT:    if (alu_rsp_valid) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    instr_ready   = (state == IDLE);
    alu_req_valid = (state == ISSUE);
    busy          = (state != IDLE);
  end

  // Operands are captured at accept; a same-cycle load to a source register is forwarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= OP_ADD;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      flags_r <= '0;
    end else begin
      if (accept) begin
        op_q <= opcode_e'(instr_op);
        rd_q <= instr_rd;
        a_q  <= (ld_en && ld_addr == instr_rs1) ? ld_data : rs1_data;
        b_q  <= (ld_en && ld_addr == instr_rs2) ? ld_data : rs2_data;
      end
      if (wb_en) begin
        flags_r.zero     <= rsp_flags.zero;
        flags_r.negative <= rsp_flags.negative;
        if (updates_carry(op_q))    flags_r.carry    <= rsp_flags.carry;
        if (updates_overflow(op_q)) flags_r.overflow <= rsp_flags.overflow;
      end
    end
  end

  assign alu_op  = op_q;
  assign alu_a   = a_q;
  assign alu_b   = b_q;
  assign flags_q = flags_r;

`ifdef ALU_ISSUER_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_instr_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (wb_en)                           perf_instr_cnt <= perf_instr_cnt + 32'd1;
      if (alu_req_valid && !alu_req_ready) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
